wb_merge_unit: RTL and testbench

- Parametrised successor to the single-divider writeback stage.
- Merges the in-order main-pipeline writeback with NUM_CH out-of-order completion channels (divider, future multiplier/FPU) onto the single register-file write port.
- Unlike the previous stage, a completion result never overrides or drops a main-pipeline write. Completions are queued in a FIFO and drained into idle writeback slots, with round-robin channel arbitration, starvation-driven stall request and a pending-destination query for hazard logic.

---
 rtl/wb_merge_if.sv | 57 +++++
 rtl/wb_merge_unit.sv | 163 ++++++++++++++++
 tb/tb_wb_merge_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_merge_if.sv
// wb_merge_if: bundle of all non-clock signals of wb_merge_unit.
//   master : side that drives the main writeback slot, the completion channels
//            and the hazard query, and observes the register-file port.
//   slave  : wb_merge_unit itself.
interface wb_merge_if #(
    parameter int XLEN       = 32,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int RA_W       = 5
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // main writeback slot
    logic                   w_valid;
    logic [XLEN-1:0]        w_pc;
    logic [XLEN-1:0]        w_inst;
    logic [XLEN-1:0]        w_alu_result;
    logic [XLEN-1:0]        w_mem_data;
    logic [RA_W-1:0]        w_rd_addr;
    logic                   w_reg_we;
    logic                   w_load;
    logic [2:0]             w_funct3;
    logic [1:0]             w_byte_offset;
    // completion channels
    logic [NUM_CH-1:0]      ch_valid;
    logic [NUM_CH-1:0]      ch_ready;
    logic [NUM_CH*RA_W-1:0] ch_dst;
    logic [NUM_CH*XLEN-1:0] ch_data;
    // hazard query / status
    logic [RA_W-1:0]        chk_addr;
    logic                   chk_pending;
    logic                   stall_req;
    logic [CNT_W-1:0]       fifo_count;
    // register-file write port and trace
    logic                   rf_we;
    logic [RA_W-1:0]        rf_dst;
    logic [XLEN-1:0]        rf_data;
    logic                   trace_valid;
    logic [XLEN-1:0]        trace_pc;
    logic [XLEN-1:0]        trace_inst;

    modport master (
        output w_valid, w_pc, w_inst, w_alu_result, w_mem_data, w_rd_addr,
               w_reg_we, w_load, w_funct3, w_byte_offset,
               ch_valid, ch_dst, ch_data, chk_addr,
        input  ch_ready, chk_pending, stall_req, fifo_count,
               rf_we, rf_dst, rf_data, trace_valid, trace_pc, trace_inst
    );

    modport slave (
        input  w_valid, w_pc, w_inst, w_alu_result, w_mem_data, w_rd_addr,
               w_reg_we, w_load, w_funct3, w_byte_offset,
               ch_valid, ch_dst, ch_data, chk_addr,
        output ch_ready, chk_pending, stall_req, fifo_count,
               rf_we, rf_dst, rf_data, trace_valid, trace_pc, trace_inst
    );
endinterface

// File: rtl/wb_merge_unit.sv
// wb_merge_unit: merges the in-order main writeback with NUM_CH out-of-order
// completion channels onto one register-file write port. Main writes always
// win; completions wait in a FIFO and drain into idle slots.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : wb_merge_if.slave -- main slot, channel handshake, hazard
//                query, stall request, FIFO occupancy, rf_* and trace_*
module wb_merge_unit #(
    parameter int XLEN         = 32,
    parameter int NUM_CH       = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int RA_W         = 5
) (
    input logic      clk,
    input logic      rst_n,
    wb_merge_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [RA_W-1:0]  q_dst  [FIFO_DEPTH];
    logic [XLEN-1:0]  q_data [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CH_W-1:0]  rr_ptr;
    logic [AGE_W-1:0] age, age_nxt;
    logic             stall_q;
    logic             rf_we_q, tv_q;
    logic [RA_W-1:0]  rf_dst_q;
    logic [XLEN-1:0]  rf_data_q, tpc_q, tinst_q;

    // ---------------- load extraction ----------------
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_val;

    always_comb begin
        ld_byte = bus.w_mem_data[8*bus.w_byte_offset +: 8];
        ld_half = bus.w_byte_offset[1] ? bus.w_mem_data[31:16] : bus.w_mem_data[15:0];
        case (bus.w_funct3)
            3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_val = bus.w_mem_data;
        endcase
    end

    // ---------------- round-robin grant ----------------
    logic            gnt_any, accept, enq, deq, main_busy;
    logic [CH_W-1:0] gnt_idx;
    logic [RA_W-1:0] sel_dst;
    logic [XLEN-1:0] sel_data;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_any && bus.ch_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(idx);
            end
        end
    end

    // Full check uses pre-dequeue occupancy so a full FIFO never accepts.
    assign accept    = gnt_any && (count < CNT_W'(FIFO_DEPTH));
    assign sel_dst   = bus.ch_dst[gnt_idx*RA_W +: RA_W];
    assign sel_data  = bus.ch_data[gnt_idx*XLEN +: XLEN];
    assign enq       = accept && (sel_dst != '0);   // x0 results are acked and dropped
    assign main_busy = bus.w_valid && bus.w_reg_we && (bus.w_rd_addr != '0);
    assign deq       = !main_busy && (count != '0);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            bus.ch_ready[i] = accept && (gnt_idx == CH_W'(i));
    end

    // ---------------- hazard query ----------------
    logic [FIFO_DEPTH-1:0] hit;
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_hit
        logic [PTR_W-1:0] off;
        assign off    = PTR_W'(i) - rd_ptr;   // position relative to head
        assign hit[i] = ({1'b0, off} < count) && (q_dst[i] == bus.chk_addr);
    end
    assign bus.chk_pending = (|hit) && (bus.chk_addr != '0);

    // ---------------- head age ----------------
    always_comb begin
        if (count == '0 || deq)              age_nxt = '0;
        else if (age < AGE_W'(STARVE_LIMIT)) age_nxt = age + 1'b1;
        else                                 age_nxt = age;
    end

    // ---------------- storage (no reset needed; validity comes from count) ----------------
    always_ff @(posedge clk) begin
        if (enq) begin
            q_dst[wr_ptr]  <= sel_dst;
            q_data[wr_ptr] <= sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            rr_ptr    <= '0;
            age       <= '0;
            stall_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_dst_q  <= '0;
            rf_data_q <= '0;
            tv_q      <= 1'b0;
            tpc_q     <= '0;
            tinst_q   <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept)
                rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            age     <= age_nxt;
            stall_q <= (age_nxt >= AGE_W'(STARVE_LIMIT));

            if (main_busy) begin
                rf_we_q   <= 1'b1;
                rf_dst_q  <= bus.w_rd_addr;
                rf_data_q <= bus.w_load ? ld_val : bus.w_alu_result;
            end else if (deq) begin
                rf_we_q   <= 1'b1;
                rf_dst_q  <= q_dst[rd_ptr];
                rf_data_q <= q_data[rd_ptr];
            end else begin
                rf_we_q   <= 1'b0;
            end

            tv_q    <= bus.w_valid;
            tpc_q   <= (bus.w_valid && bus.w_inst != '0) ? bus.w_pc : '0;
            tinst_q <= bus.w_valid ? bus.w_inst : '0;
        end
    end

    assign bus.stall_req   = stall_q;
    assign bus.fifo_count  = count;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_dst      = rf_dst_q;
    assign bus.rf_data     = rf_data_q;
    assign bus.trace_valid = tv_q;
    assign bus.trace_pc    = tpc_q;
    assign bus.trace_inst  = tinst_q;
endmodule

// File: tb/tb_wb_merge_unit.sv
// tb_wb_merge_unit: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the merge stage.
module tb_wb_merge_unit;
    localparam int XLEN = 32, NUM_CH = 2, FIFO_DEPTH = 4, STARVE_LIMIT = 8, RA_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_merge_if #(.XLEN(XLEN), .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .RA_W(RA_W)) bus ();

    wb_merge_unit #(.XLEN(XLEN), .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH),
                    .STARVE_LIMIT(STARVE_LIMIT), .RA_W(RA_W))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { logic [RA_W-1:0] dst; logic [XLEN-1:0] data; } ent_t;

    // reference model state (values the registered outputs should show now)
    ent_t            q[$];
    int              rr, age;
    bit              m_stall, m_we, m_tv;
    logic [RA_W-1:0] m_dst;
    logic [XLEN-1:0] m_data, m_tpc, m_tinst;
    int              n_checks = 0, n_errors = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld_ext(logic [31:0] mem, logic [2:0] f3, logic [1:0] off);
        int unsigned b, h;
        b = (mem >> (8 * off)) & 32'hFF;
        h = (mem >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128)   ? b - 256   : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return mem;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        rr = 0; age = 0; m_stall = 0; m_we = 0; m_dst = '0; m_data = '0;
        m_tv = 0; m_tpc = '0; m_tinst = '0;
    endtask

    task automatic idle();
        bus.w_valid = 0; bus.w_pc = '0; bus.w_inst = '0; bus.w_alu_result = '0;
        bus.w_mem_data = '0; bus.w_rd_addr = '0; bus.w_reg_we = 0; bus.w_load = 0;
        bus.w_funct3 = '0; bus.w_byte_offset = '0;
        bus.ch_valid = '0; bus.ch_dst = '0; bus.ch_data = '0; bus.chk_addr = '0;
    endtask

    task automatic main_alu(logic [RA_W-1:0] rd, logic [XLEN-1:0] v);
        bus.w_valid = 1; bus.w_reg_we = 1; bus.w_rd_addr = rd; bus.w_load = 0;
        bus.w_alu_result = v; bus.w_inst = 32'h13; bus.w_pc = 32'h100;
    endtask

    task automatic set_ch(int c, logic [RA_W-1:0] d, logic [XLEN-1:0] v);
        bus.ch_dst[c*RA_W +: RA_W]  = d;
        bus.ch_data[c*XLEN +: XLEN] = v;
    endtask

    // Inputs are driven by the caller just after a rising edge; step checks
    // everything mid-cycle, advances the model, and returns 1 unit past the next edge.
    task automatic step();
        int g;
        bit acc, busy, deq, exp_pend;
        logic [NUM_CH-1:0] exp_rdy;
        logic [RA_W-1:0] gd;
        #2;
        check("rf_we", bus.rf_we, m_we);
        check("rf_dst", bus.rf_dst, m_dst);
        check("rf_data", bus.rf_data, m_data);
        check("rf_we_x0", bus.rf_we && bus.rf_dst == '0, 0);
        check("trace_valid", bus.trace_valid, m_tv);
        check("trace_pc", bus.trace_pc, m_tpc);
        check("trace_inst", bus.trace_inst, m_tinst);
        check("stall_req", bus.stall_req, m_stall);
        check("fifo_count", bus.fifo_count, q.size());

        g = -1;
        for (int k = 0; k < NUM_CH; k++) begin
            int idx = (rr + k) % NUM_CH;
            if (g < 0 && bus.ch_valid[idx]) g = idx;
        end
        acc = (g >= 0) && (q.size() < FIFO_DEPTH);
        exp_rdy = '0;
        if (acc) exp_rdy[g] = 1'b1;
        exp_pend = 0;
        if (bus.chk_addr != 0)
            foreach (q[i]) if (q[i].dst == bus.chk_addr) exp_pend = 1;
        check("ch_ready", bus.ch_ready, exp_rdy);
        check("chk_pending", bus.chk_pending, exp_pend);

        busy = bus.w_valid && bus.w_reg_we && bus.w_rd_addr != 0;
        deq  = !busy && q.size() > 0;
        if (q.size() == 0 || deq) age = 0;
        else if (age < STARVE_LIMIT) age++;
        m_stall = (age >= STARVE_LIMIT);
        if (busy) begin
            m_we = 1; m_dst = bus.w_rd_addr;
            m_data = bus.w_load ? ld_ext(bus.w_mem_data, bus.w_funct3, bus.w_byte_offset)
                                : bus.w_alu_result;
        end else if (deq) begin
            m_we = 1; m_dst = q[0].dst; m_data = q[0].data;
            q.delete(0);
        end else m_we = 0;
        if (acc) begin
            gd = bus.ch_dst[g*RA_W +: RA_W];
            if (gd != 0) q.push_back('{gd, bus.ch_data[g*XLEN +: XLEN]});
            rr = (g + 1) % NUM_CH;
        end
        m_tv   = bus.w_valid;
        m_tpc  = (bus.w_valid && bus.w_inst != 0) ? bus.w_pc : '0;
        m_tinst = bus.w_valid ? bus.w_inst : '0;
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_rf_we"}, bus.rf_we, 0);
        check({tag, "_rf_dst"}, bus.rf_dst, 0);
        check({tag, "_rf_data"}, bus.rf_data, 0);
        check({tag, "_trace"}, {bus.trace_valid, bus.trace_pc, bus.trace_inst}, 0);
        check({tag, "_stall"}, bus.stall_req, 0);
        check({tag, "_count"}, bus.fifo_count, 0);
    endtask

    task automatic rand_phase(int cycles, int busy_pct, int ch_pct);
        for (int n = 0; n < cycles; n++) begin
            bus.w_valid       = ($urandom_range(99) < busy_pct);
            bus.w_reg_we      = ($urandom_range(9) != 0);
            bus.w_rd_addr     = ($urandom_range(7) == 0) ? '0 : RA_W'($urandom);
            bus.w_load        = $urandom_range(1);
            bus.w_funct3      = 3'($urandom);
            bus.w_byte_offset = 2'($urandom);
            bus.w_mem_data    = $urandom;
            bus.w_alu_result  = $urandom;
            bus.w_pc          = $urandom;
            bus.w_inst        = ($urandom_range(7) == 0) ? '0 : $urandom;
            for (int c = 0; c < NUM_CH; c++) begin
                bus.ch_valid[c] = ($urandom_range(99) < ch_pct);
                set_ch(c, ($urandom_range(7) == 0) ? '0 : RA_W'($urandom), $urandom);
            end
            if (q.size() > 0 && $urandom_range(1)) bus.chk_addr = q[$urandom_range(q.size()-1)].dst;
            else bus.chk_addr = RA_W'($urandom);
            step();
        end
    endtask

    initial begin
        idle();
        model_reset();
        #3;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1;

        // main only: LB at offset 2 of 0x0080_0000
        bus.w_valid = 1; bus.w_reg_we = 1; bus.w_rd_addr = 5; bus.w_load = 1;
        bus.w_funct3 = 3'b000; bus.w_byte_offset = 2; bus.w_mem_data = 32'h0080_0000;
        bus.w_inst = 32'h0000_0283; bus.w_pc = 32'h40;
        step();
        check("lb_we", bus.rf_we, 1);
        check("lb_dst", bus.rf_dst, 5);
        check("lb_data", bus.rf_data, 32'hFFFF_FF80);
        bus.w_rd_addr = 0;
        step();
        check("rd0_we", bus.rf_we, 0);

        // collision: main x3 and channel 0 -> x7 in the same cycle
        idle();
        main_alu(3, 32'h11);
        bus.ch_valid = 2'b01; set_ch(0, 7, 32'h22);
        step();
        check("col_main", {bus.rf_we, bus.rf_dst, bus.rf_data}, {1'b1, 5'd3, 32'h11});
        idle();
        step();
        check("col_ch", {bus.rf_we, bus.rf_dst, bus.rf_data}, {1'b1, 5'd7, 32'h22});

        // round robin with main busy until FIFO full
        idle();
        main_alu(1, 32'hAA);
        bus.ch_valid = 2'b11; set_ch(0, 10, 32'hC0); set_ch(1, 11, 32'hC1);
        for (int n = 0; n < 6; n++) step();
        #1;
        check("rr_full", bus.fifo_count, FIFO_DEPTH);
        check("rr_ready", bus.ch_ready, 0);

        // drain, then starvation on a single entry
        idle();
        for (int n = 0; n < 5; n++) step();
        main_alu(1, 32'h55);
        bus.ch_valid = 2'b01; set_ch(0, 9, 32'h99); bus.chk_addr = 9;
        step();
        bus.ch_valid = '0;
        for (int n = 0; n < 7; n++) step();
        check("starve_early", bus.stall_req, 0);
        step();
        check("starve_stall", bus.stall_req, 1);
        check("haz_pending", bus.chk_pending, 1);
        bus.w_valid = 0;
        step();
        check("starve_drain", {bus.rf_we, bus.rf_dst, bus.stall_req}, {1'b1, 5'd9, 1'b0});
        check("haz_clear", bus.chk_pending, 0);

        // x0 completion: acked, dropped
        idle();
        bus.ch_valid = 2'b01; set_ch(0, 0, 32'hDEAD);
        step();
        check("x0_count", bus.fifo_count, 0);
        bus.ch_valid = '0;
        step();
        check("x0_nowrite", bus.rf_we, 0);

        // reset with three queued entries
        main_alu(2, 32'h77);
        bus.ch_valid = 2'b01; set_ch(0, 12, 32'h12);
        for (int n = 0; n < 3; n++) step();
        check("pre_rst_count", bus.fifo_count, 3);
        idle();
        #2 rst_n = 0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        for (int n = 0; n < 4; n++) step();

        // randomized traffic
        rand_phase(400, 90, 70);
        rand_phase(400, 30, 50);
        rand_phase(400, 60, 90);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
